// File: rtl/axis_pkg.sv
// Shared types and helpers for the axis_master transmit block.
package axis_pkg;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // Address width for a buffer of n words; never below one bit.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int strb_width(input int dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/axis_master_if.sv
// Load port plus AXI-Stream master bus for axis_master.
// wr_strb exists only when AXIS_MASTER_TSTRB_EN is defined.
interface axis_master_if
  import axis_pkg::*;
#(
  parameter int DW = 32
);
  localparam int SW = strb_width(DW);

  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          wr_last;
`ifdef AXIS_MASTER_TSTRB_EN
  logic [SW-1:0] wr_strb;
`endif
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic          m_axis_tlast;
  logic          busy;

`ifdef AXIS_MASTER_TSTRB_EN
  modport master (
    input  wr_valid, wr_data, wr_last, wr_strb, m_axis_tready,
    output wr_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, busy
  );
  modport slave (
    output wr_valid, wr_data, wr_last, wr_strb, m_axis_tready,
    input  wr_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, busy
  );
`else
  modport master (
    input  wr_valid, wr_data, wr_last, m_axis_tready,
    output wr_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, busy
  );
  modport slave (
    output wr_valid, wr_data, wr_last, m_axis_tready,
    input  wr_ready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast, busy
  );
`endif

endinterface

// File: rtl/axis_pkt_buffer.sv
// Packet store: synchronous write, asynchronous read so a word is visible
// in the same cycle its read address is presented.
module axis_pkt_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_master.sv
// Store-and-forward AXI-Stream master: load one packet, then stream it out.
// Define AXIS_MASTER_TSTRB_EN to carry per-word strobes through the buffer.
module axis_master
  import axis_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int C_DEPTH           = 8,
  parameter int C_START_COUNT     = 32
) (
  input logic          m_axis_aclk,
  input logic          m_axis_areset,
  axis_master_if.master axis
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = strb_width(DW);
  localparam int PW = clogb2(C_DEPTH);
`ifdef AXIS_MASTER_TSTRB_EN
  localparam int BUF_W = DW + SW;
`else
  localparam int BUF_W = DW;
`endif

  state_t          state, state_nx;
  logic [31:0]     init_cnt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            tvalid;
  logic            load, close, xfer, at_last;
  logic [BUF_W-1:0] wr_word, rd_word;

  assign axis.wr_ready = (state == S_LOAD);
  assign axis.busy     = (state == S_SEND);

  assign load    = axis.wr_valid && axis.wr_ready;
  // Writing the final slot closes the packet even without wr_last.
  assign close   = load && (axis.wr_last || (wr_ptr == PW'(C_DEPTH - 1)));
  assign xfer    = tvalid && axis.m_axis_tready;
  assign at_last = ({1'b0, rd_ptr} == (count - (PW+1)'(1)));

`ifdef AXIS_MASTER_TSTRB_EN
  assign wr_word = {axis.wr_strb, axis.wr_data};
  assign axis.m_axis_tstrb = tvalid ? rd_word[BUF_W-1 -: SW] : '0;
`else
  assign wr_word = axis.wr_data;
  assign axis.m_axis_tstrb = {SW{tvalid}};
`endif
  assign axis.m_axis_tdata  = tvalid ? rd_word[DW-1:0] : '0;
  assign axis.m_axis_tlast  = tvalid && at_last;
  assign axis.m_axis_tvalid = tvalid;

  axis_pkt_buffer #(
    .W    (BUF_W),
    .DEPTH(C_DEPTH),
    .AW   (PW)
  ) u_buf (
    .clk  (m_axis_aclk),
    .we   (load),
    .waddr(wr_ptr),
    .wdata(wr_word),
    .raddr(rd_ptr),
    .rdata(rd_word)
  );

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) state <= S_INIT;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_INIT:  if (init_cnt == 32'(C_START_COUNT - 1)) state_nx = S_LOAD;
      S_LOAD:  if (close) state_nx = S_SEND;
      S_SEND:  if (xfer && at_last) state_nx = S_LOAD;
      default: state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge m_axis_aclk) begin
    if (m_axis_areset) begin
      init_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tvalid   <= 1'b0;
    end else begin
      // tvalid is a register of the next state, never a function of tready.
      tvalid <= (state_nx == S_SEND);
      if (state == S_INIT) init_cnt <= init_cnt + 32'd1;
      if (load)  wr_ptr <= wr_ptr + PW'(1);
      if (close) count  <= {1'b0, wr_ptr} + (PW+1)'(1);
      if (xfer) begin
        if (at_last) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_master.sv
// Bench for axis_master: vector table, hand sequences and random packets,
// checked against a queue-based packetisation model.
module tb_axis_master;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int SC    = 4;
  localparam int SW    = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_master_if #(.DW(DW)) axis ();

  axis_master #(
    .C_AXIS_DATA_WIDTH(DW),
    .C_DEPTH          (DEPTH),
    .C_START_COUNT    (SC)
  ) dut (
    .m_axis_aclk  (clk),
    .m_axis_areset(rst),
    .axis         (axis)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    bit            last;
  } word_t;

  typedef struct {
    int            len;
    bit            term;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    int            rmode;
    bit [7:0]      pat;
    int            pat_len;
    logic [SW-1:0] strb0;
    logic [SW-1:0] strbn;
    int            exp_pkts;
    int            exp_words;
  } vec_t;

  int errors = 0;
  int checks = 0;

  word_t         exp_q[$];
  int            len_q[$];
  logic [DW-1:0] ld_data[$];
  bit            ld_last[$];
  logic [SW-1:0] ld_strb[$];

  int cyc = 0;
  int close_cyc = -1;
  int ready_cyc = -1;
  int words_seen = 0, pkts_seen = 0, in_pkt = 0;
  int rmode = 0;
  bit [7:0] pat = 8'h00;
  int pat_len = 0, pat_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // tready driver: 0 always high, 1 random, 2 pattern from first valid cycle, 3 held low.
  always @(posedge clk) begin
    #2;
    case (rmode)
      0: axis.m_axis_tready = 1'b1;
      1: axis.m_axis_tready = ($urandom_range(0, 3) != 0);
      2: begin
        if (!axis.m_axis_tvalid) begin
          pat_idx = 0;
          axis.m_axis_tready = 1'b1;
        end else begin
          axis.m_axis_tready = (pat_idx < pat_len) ? pat[pat_idx] : 1'b1;
          pat_idx++;
        end
      end
      default: axis.m_axis_tready = 1'b0;
    endcase
  end

  // Stream monitor and protocol checks, sampled on the falling edge.
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic [SW-1:0] prev_s = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      len_q.delete();
      in_pkt = 0;
      prev_v = 1'b0;
      close_cyc = -1;
      ready_cyc = -1;
    end else begin
      if (cyc == ready_cyc) begin
        chk("wr_ready_after_tlast", axis.wr_ready, 1);
        chk("tvalid_after_tlast", axis.m_axis_tvalid, 0);
      end
      if (axis.m_axis_tvalid && !prev_v) chk("first_tvalid_latency", cyc, close_cyc);
      if (prev_v && !(prev_r && prev_l)) chk("tvalid_held_mid_pkt", axis.m_axis_tvalid, 1);
      if (prev_v && !prev_r) begin
        chk("stall_tdata", axis.m_axis_tdata, prev_d);
        chk("stall_tstrb", axis.m_axis_tstrb, prev_s);
        chk("stall_tlast", axis.m_axis_tlast, prev_l);
      end
      if (axis.m_axis_tvalid) begin
        chk("wr_ready_in_send", axis.wr_ready, 0);
        chk("busy_in_send", axis.busy, 1);
      end
`ifndef AXIS_MASTER_TSTRB_EN
      else chk("tstrb_idle", axis.m_axis_tstrb, 0);
`endif
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        words_seen++;
        in_pkt++;
        chk("word_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          word_t e;
          e = exp_q.pop_front();
          chk("tdata", axis.m_axis_tdata, e.data);
          chk("tstrb", axis.m_axis_tstrb, e.strb);
          chk("tlast", axis.m_axis_tlast, e.last);
        end
        if (axis.m_axis_tlast) begin
          pkts_seen++;
          if (len_q.size() != 0) chk("pkt_len", in_pkt, len_q.pop_front());
          in_pkt = 0;
          ready_cyc = cyc + 1;
        end
      end
      prev_v = axis.m_axis_tvalid;
      prev_r = axis.m_axis_tready;
      prev_l = axis.m_axis_tlast;
      prev_d = axis.m_axis_tdata;
      prev_s = axis.m_axis_tstrb;
    end
  end

  // Reference packetisation: a packet ends at wr_last or after DEPTH words.
  task automatic build_expected();
    int n = 0;
    for (int i = 0; i < ld_data.size(); i++) begin
      word_t e;
      e.data = ld_data[i];
`ifdef AXIS_MASTER_TSTRB_EN
      e.strb = ld_strb[i];
`else
      e.strb = '1;
`endif
      n++;
      e.last = ld_last[i] || (n == DEPTH);
      exp_q.push_back(e);
      if (e.last) begin
        len_q.push_back(n);
        n = 0;
      end
    end
  endtask

  task automatic load_list(input bit gaps);
    int n = 0;
    for (int i = 0; i < ld_data.size(); i++) begin
      int w = 0;
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          axis.wr_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      axis.wr_valid = 1'b1;
      axis.wr_data  = ld_data[i];
      axis.wr_last  = ld_last[i];
`ifdef AXIS_MASTER_TSTRB_EN
      axis.wr_strb  = ld_strb[i];
`endif
      @(negedge clk);
      while (!axis.wr_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      chk("load_ready", axis.wr_ready, 1);
      if (!axis.wr_ready) begin
        axis.wr_valid = 1'b0;
        return;
      end
      n++;
      if (ld_last[i] || n == DEPTH) begin
        close_cyc = cyc + 1;
        n = 0;
      end
      @(posedge clk); #1;
    end
    axis.wr_valid = 1'b0;
    axis.wr_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || axis.m_axis_tvalid) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Called on a falling edge right after reset release.
  task automatic measure_init(input string nm);
    int z = 0;
    bit v = 1'b0;
    while (!axis.wr_ready && z < 100) begin
      z++;
      if (axis.m_axis_tvalid) v = 1'b1;
      @(negedge clk);
    end
    chk(nm, z, SC);
    chk("tvalid_during_init", v, 0);
  endtask

  task automatic clear_list();
    ld_data.delete();
    ld_last.delete();
    ld_strb.delete();
  endtask

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ws0, ps0, ep, w;

    vecs[0] = '{3,  1'b1, 32'h11,   32'h11,  0, 8'h00, 0, 4'hF,    4'hF,    1, 3};
    vecs[1] = '{8,  1'b0, 32'h0,    32'h1,   0, 8'h00, 0, 4'hF,    4'hF,    1, 8};
    vecs[2] = '{3,  1'b1, 32'hA1,   32'h1,   2, 8'h29, 6, 4'hF,    4'hF,    1, 3};
    vecs[3] = '{2,  1'b1, 32'h55,   32'h100, 0, 8'h00, 0, 4'b0011, 4'b1111, 1, 2};
    vecs[4] = '{11, 1'b1, 32'h1000, 32'h1,   1, 8'h00, 0, 4'h5,    4'hA,    2, 11};
    vecs[5] = '{1,  1'b1, 32'hDEADBEEF, 32'h0, 1, 8'h00, 0, 4'h9,  4'h9,    1, 1};

    axis.wr_valid = 1'b0;
    axis.wr_data  = '0;
    axis.wr_last  = 1'b0;
`ifdef AXIS_MASTER_TSTRB_EN
    axis.wr_strb  = '0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", axis.wr_ready, 0);
    chk("rst_tvalid", axis.m_axis_tvalid, 0);
    chk("rst_tlast", axis.m_axis_tlast, 0);
    chk("rst_tdata", axis.m_axis_tdata, 0);
    chk("rst_busy", axis.busy, 0);
    chk("rst_tstrb", axis.m_axis_tstrb, 0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    measure_init("init_wait_cycles");
    @(posedge clk); #1;

    foreach (vecs[k]) begin
      clear_list();
      for (int i = 0; i < vecs[k].len; i++) begin
        ld_data.push_back(vecs[k].base + vecs[k].step * i);
        ld_last.push_back(vecs[k].term && (i == vecs[k].len - 1));
        ld_strb.push_back((i == 0) ? vecs[k].strb0 : vecs[k].strbn);
      end
      rmode   = vecs[k].rmode;
      pat     = vecs[k].pat;
      pat_len = vecs[k].pat_len;
      build_expected();
      ws0 = words_seen;
      ps0 = pkts_seen;
      load_list(1'b0);
      drain();
      chk("vec_pkts", pkts_seen - ps0, vecs[k].exp_pkts);
      chk("vec_words", words_seen - ws0, vecs[k].exp_words);
    end

    rmode = 1;
    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(1, 20);
      clear_list();
      for (int i = 0; i < n; i++) begin
        ld_data.push_back($urandom);
        ld_last.push_back((i == n - 1) || ($urandom_range(0, 3) == 0));
        ld_strb.push_back(SW'($urandom));
      end
      build_expected();
      ep  = len_q.size();
      ws0 = words_seen;
      ps0 = pkts_seen;
      load_list(1'b1);
      drain();
      chk("rand_pkts", pkts_seen - ps0, ep);
      chk("rand_words", words_seen - ws0, n);
    end

    // Reset in the middle of a 4-word send.
    @(posedge clk); #1;
    rmode = 0;
    clear_list();
    for (int i = 0; i < 4; i++) begin
      ld_data.push_back(32'hB0 + i);
      ld_last.push_back(i == 3);
      ld_strb.push_back('1);
    end
    build_expected();
    ws0 = words_seen;
    load_list(1'b0);
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (words_seen < ws0 + 1 && w < 50);
    chk("first_word_before_reset", words_seen - ws0, 1);
    rmode = 3;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_tvalid", axis.m_axis_tvalid, 0);
    chk("abort_busy", axis.busy, 0);
    chk("abort_wr_ready", axis.wr_ready, 0);
    chk("abort_tlast", axis.m_axis_tlast, 0);
    measure_init("reinit_wait_cycles");
    @(posedge clk); #1;
    rmode = 0;
    clear_list();
    for (int i = 0; i < 3; i++) begin
      ld_data.push_back(32'hC0 + i);
      ld_last.push_back(i == 2);
      ld_strb.push_back(4'h6);
    end
    build_expected();
    ws0 = words_seen;
    load_list(1'b0);
    drain();
    chk("post_reset_words", words_seen - ws0, 3);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
